sobel_edge: RTL and testbench

- Downstream neighbour of the 3x3 Gaussian blur stage in the DVP video pipeline; consumes its 24-bit RGB stream (vs/de/data).
- Converts each pixel to 8-bit luma and builds a 3x3 window from two internal line buffers.
- Computes the Sobel gradient magnitude and emits either a binary edge map or a saturated gray magnitude, with a combinational bypass when disabled.

---
 rtl/sobel_edge.sv | 177 +++++++++++++++++
 tb/tb_sobel_edge.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sobel_edge.sv
// Sobel edge stage: RGB -> luma, 3x3 window from two line buffers, gradient
// magnitude rendered as a binary edge map or saturated gray, 5-clock latency.
module sobel_edge #(
    parameter logic [11:0] IMG_HDISP = 12'd1280,
    parameter logic [11:0] IMG_VDISP = 12'd720
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EN,
    input  logic        mode,
    input  logic [7:0]  thresh,
    input  logic        per_vs,
    input  logic        per_de,
    input  logic [23:0] per_data,
    output logic        post_vs,
    output logic        post_de,
    output logic [23:0] post_data
);

    localparam int LAT   = 5;
    localparam int DEPTH = int'(IMG_HDISP);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    if (IMG_VDISP > 12'd2047) begin : g_vdisp_chk
        $error("IMG_VDISP exceeds the 11-bit row counter");
    end

    // vs/de delay lines; index 1 is the S0 register
    logic [LAT:1] vs_pipe, de_pipe;

    // ---------------- S0: luma + position counters ----------------
    logic [15:0]   luma_sum;
    logic [7:0]    y_s0;
    logic [CW-1:0] cnt_col;
    logic [10:0]   cnt_row;
    logic [AW-1:0] col_s0;
    logic [10:0]   row_s0;
    logic          over_s0;
    logic          col_over, vs_rise, de_fall;

    assign luma_sum = 16'd77  * {8'd0, per_data[23:16]}
                    + 16'd150 * {8'd0, per_data[15:8]}
                    + 16'd29  * {8'd0, per_data[7:0]};

    assign col_over = (cnt_col >= CW'(DEPTH));
    assign vs_rise  = per_vs & ~vs_pipe[1];
    assign de_fall  = de_pipe[1] & ~per_de;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_pipe <= '0;
            de_pipe <= '0;
            cnt_col <= '0;
            cnt_row <= '0;
            y_s0    <= '0;
            col_s0  <= '0;
            row_s0  <= '0;
            over_s0 <= 1'b0;
        end else begin
            vs_pipe <= {vs_pipe[LAT-1:1], per_vs};
            de_pipe <= {de_pipe[LAT-1:1], per_de};
            // cnt_col stops one past the last column so long lines are flagged
            if (per_de) begin
                if (!col_over) cnt_col <= cnt_col + CW'(1);
            end else begin
                cnt_col <= '0;
            end
            if (vs_rise)
                cnt_row <= '0;
            else if (de_fall && cnt_row != 11'h7FF)
                cnt_row <= cnt_row + 11'd1;
            y_s0    <= luma_sum[15:8];
            col_s0  <= col_over ? AW'(DEPTH - 1) : cnt_col[AW-1:0];
            row_s0  <= vs_rise ? 11'd0 : cnt_row;
            over_s0 <= col_over;
        end
    end

    // ---------------- S1: line buffers + window ----------------
    logic [7:0] lb0 [0:DEPTH-1];
    logic [7:0] lb1 [0:DEPTH-1];
    logic [7:0] lb0_q, lb1_q;
    logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic       border_s1;

    assign lb0_q = lb0[col_s0];
    assign lb1_q = lb1[col_s0];

    always_ff @(posedge clk) begin
        if (de_pipe[1] && !over_s0) begin
            lb0[col_s0] <= y_s0;
            lb1[col_s0] <= lb0_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {p11, p12, p13} <= '0;
            {p21, p22, p23} <= '0;
            {p31, p32, p33} <= '0;
            border_s1 <= 1'b0;
        end else if (de_pipe[1]) begin
            {p11, p12, p13} <= {p12, p13, lb1_q};
            {p21, p22, p23} <= {p22, p23, lb0_q};
            {p31, p32, p33} <= {p32, p33, y_s0};
            border_s1 <= (row_s0 < 11'd2) || (col_s0 < AW'(2));
        end
    end

    // ---------------- S2: gradients ----------------
    logic [9:0]         gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [10:0] gx, gy;
    logic               border_s2;

    assign gx_pos = {2'b0, p13} + {1'b0, p23, 1'b0} + {2'b0, p33};
    assign gx_neg = {2'b0, p11} + {1'b0, p21, 1'b0} + {2'b0, p31};
    assign gy_pos = {2'b0, p31} + {1'b0, p32, 1'b0} + {2'b0, p33};
    assign gy_neg = {2'b0, p11} + {1'b0, p12, 1'b0} + {2'b0, p13};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx        <= '0;
            gy        <= '0;
            border_s2 <= 1'b0;
        end else begin
            // each side is at most 1020, so the 11-bit difference cannot wrap
            gx        <= {1'b0, gx_pos} - {1'b0, gx_neg};
            gy        <= {1'b0, gy_pos} - {1'b0, gy_neg};
            border_s2 <= border_s1;
        end
    end

    // ---------------- S3: magnitude ----------------
    logic [10:0] abs_x, abs_y;
    logic [11:0] mag;
    logic        border_s3;

    assign abs_x = gx[10] ? 11'(-gx) : 11'(gx);
    assign abs_y = gy[10] ? 11'(-gy) : 11'(gy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag       <= '0;
            border_s3 <= 1'b0;
        end else begin
            mag       <= {1'b0, abs_x} + {1'b0, abs_y};
            border_s3 <= border_s2;
        end
    end

    // ---------------- S4: render ----------------
    logic [7:0]  gray;
    logic [23:0] result, data_s4;

    assign gray = (mag > 12'd255) ? 8'hFF : mag[7:0];

    always_comb begin
        result = 24'h0;
        if (!border_s3) begin
            if (mode)
                result = {gray, gray, gray};
            else if (mag >= {4'b0, thresh})
                result = 24'hFFFFFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_s4 <= '0;
        else        data_s4 <= result;
    end

    assign post_vs   = EN ? vs_pipe[LAT] : per_vs;
    assign post_de   = EN ? de_pipe[LAT] : per_de;
    assign post_data = EN ? data_s4      : per_data;

endmodule

// File: tb/tb_sobel_edge.sv
// Directed bench for sobel_edge on a 16x8 image: flat, vertical and horizontal
// steps, bypass, EN raised mid-frame and a reset pulse mid-line.
module tb_sobel_edge;

    localparam int H   = 16;
    localparam int V   = 8;
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        mode = 1'b0;
    logic [7:0]  thresh = 8'd1;
    logic        per_vs = 1'b0;
    logic        per_de = 1'b0;
    logic [23:0] per_data = 24'h0;
    logic        post_vs, post_de;
    logic [23:0] post_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int armed_from = 32'h3FFFFFFF;

    // expectation for the input driven at each cycle, read back LAT cycles later
    logic        q_vs [8];
    logic        q_de [8];
    logic [23:0] q_data [8];

    sobel_edge #(.IMG_HDISP(12'd16), .IMG_VDISP(12'd8)) dut (
        .clk(clk), .rst_n(rst_n), .EN(en), .mode(mode), .thresh(thresh),
        .per_vs(per_vs), .per_de(per_de), .per_data(per_data),
        .post_vs(post_vs), .post_de(post_de), .post_data(post_data)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] src_pix(input int k, input int x, input int y);
        case (k)
            1:       return (x < 8) ? 24'h000000 : 24'hFFFFFF;
            2:       return (y < 4) ? 24'h000000 : 24'h404040;
            default: return 24'h808080;
        endcase
    endfunction

    // hand-derived results for the thresholds each pattern is run with
    function automatic logic [23:0] exp_pix(input int k, input int x, input int y);
        if (y < 2 || x < 2) return 24'h0;
        case (k)
            1:       return (x == 8 || x == 9) ? 24'hFFFFFF : 24'h0;
            2:       return (y == 4 || y == 5) ? 24'hFFFFFF : 24'h0;
            default: return 24'h0;
        endcase
    endfunction

    task automatic check_zero(input string tag);
        checks++;
        assert (post_vs === 1'b0) else begin
            errors++; $error("FAIL %s post_vs got=%b exp=0", tag, post_vs);
        end
        checks++;
        assert (post_de === 1'b0) else begin
            errors++; $error("FAIL %s post_de got=%b exp=0", tag, post_de);
        end
        checks++;
        assert (post_data === 24'h0) else begin
            errors++; $error("FAIL %s post_data got=%h exp=000000", tag, post_data);
        end
    endtask

    task automatic step(input logic vs, input logic de, input logic [23:0] d,
                        input logic [23:0] e);
        logic [2:0] s;
        @(posedge clk); #1;
        if (en && (cyc - LAT >= armed_from)) begin
            s = 3'((cyc - LAT) % 8);
            checks++;
            assert (post_vs === q_vs[s]) else begin
                errors++; $error("FAIL vs_delay cyc=%0d got=%b exp=%b", cyc, post_vs, q_vs[s]);
            end
            checks++;
            assert (post_de === q_de[s]) else begin
                errors++; $error("FAIL de_delay cyc=%0d got=%b exp=%b", cyc, post_de, q_de[s]);
            end
            if (q_de[s]) begin
                checks++;
                assert (post_data === q_data[s]) else begin
                    errors++;
                    $error("FAIL pixel cyc=%0d got=%h exp=%h", cyc, post_data, q_data[s]);
                end
            end
        end
        per_vs   = vs;
        per_de   = de;
        per_data = d;
        s = 3'(cyc % 8);
        q_vs[s]   = vs;
        q_de[s]   = de;
        q_data[s] = e;
        cyc++;
        if (!en) begin
            #1;
            checks++;
            assert ({post_vs, post_de, post_data} === {per_vs, per_de, per_data}) else begin
                errors++;
                $error("FAIL bypass cyc=%0d got=%b/%b/%h exp=%b/%b/%h", cyc, post_vs,
                       post_de, post_data, per_vs, per_de, per_data);
            end
        end
    endtask

    task automatic blank(input int n);
        repeat (n) step(1'b0, 1'b0, 24'h0, 24'h0);
    endtask

    // en_on: linear pixel index at which EN is raised (-1: leave EN alone)
    task automatic frame(input int k, input int en_on);
        step(1'b1, 1'b0, 24'h0, 24'h0);
        step(1'b1, 1'b0, 24'h0, 24'h0);
        blank(3);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                if (y * H + x == en_on) en = 1'b1;
                step(1'b0, 1'b1, src_pix(k, x, y), exp_pix(k, x, y));
            end
            blank(4);
        end
        blank(4);
    endtask

    initial begin
        // reset state with EN=1
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;
        armed_from = cyc;
        blank(6);

        mode = 1'b0; thresh = 8'd1;   frame(0, -1);
        mode = 1'b0; thresh = 8'd100; frame(1, -1);
        mode = 1'b1;                  frame(1, -1);
        mode = 1'b1;                  frame(2, -1);
        mode = 1'b0; thresh = 8'd255; frame(2, -1);

        // bypass with random traffic; vs ends low so the next frame sees a rise
        en = 1'b0;
        repeat (12) step(1'($urandom), 1'($urandom), 24'($urandom), 24'h0);
        blank(6);

        // EN raised in the middle of line 3
        mode = 1'b0; thresh = 8'd100;
        frame(1, 3 * H + 5);

        // reset pulse in the middle of line 2
        step(1'b1, 1'b0, 24'h0, 24'h0);
        step(1'b1, 1'b0, 24'h0, 24'h0);
        blank(3);
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < ((y == 2) ? 8 : H); x++)
                step(1'b0, 1'b1, src_pix(1, x, y), exp_pix(1, x, y));
            if (y < 2) blank(4);
        end
        rst_n = 1'b0;
        armed_from = 32'h3FFFFFFF;
        #1 check_zero("reset_async");
        repeat (3) begin
            step(1'b0, 1'b0, 24'h0, 24'h0);
            check_zero("reset_hold");
        end
        rst_n = 1'b1;
        armed_from = cyc;
        blank(6);
        frame(1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
